lsu_bus_master: RTL and testbench
=================================

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the bus cycles waited for ready_i before abort (range 1..65535).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 lsu_valid_i  input  1  SHALL mark a pipeline memory request.
REQ-005 lsu_we_i  input  1  SHALL select store (1) or load (0).
REQ-006 lsu_addr_i  input  64  SHALL carry the byte address.
REQ-007 lsu_size_i  input  2  SHALL encode the access size: 0=byte, 1=half, 2=word, 3=double.
REQ-008 lsu_unsigned_i  input  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-009 lsu_wdata_i  input  64  SHALL carry the store data, right-justified.
REQ-010 lsu_ready_o  output  1  SHALL be high when a request can be accepted.
REQ-011 lsu_done_o  output  1  SHALL be a one-cycle completion pulse.
REQ-012 lsu_rdata_o  output  64  SHALL carry the extended load result, valid with lsu_done_o.
REQ-013 lsu_err_o  output  1  SHALL flag a bus error or timeout, valid with lsu_done_o.
REQ-014 lsu_misalign_o  output  1  SHALL flag a misaligned request, valid with lsu_done_o.
REQ-015 valid_o  output  1  SHALL mark a valid bus request.
REQ-016 req_o  output  1  SHALL encode the bus direction: 1=write, 0=read.
REQ-017 addr_o  output  64  SHALL carry the bus address, the full byte address unmodified.
REQ-018 data_write_o  output  64  SHALL carry the lane-aligned write data.
REQ-019 wstrb_o  output  8  SHALL carry the byte-lane write strobes.
REQ-020 ready_i  input  1  SHALL be the responder handshake acknowledge.
REQ-021 data_read_i  input  64  SHALL carry the responder read data.
REQ-022 resp_i  input  2  SHALL carry the responder status; 2'b00=OK, any other value=error.

Function
REQ-023 The FSM SHALL have the states IDLE, BUS, DONE; lsu_ready_o SHALL be 1 only in IDLE.
REQ-024 On lsu_valid_i in IDLE, a request whose addr is not size-aligned (addr mod 2^size != 0) SHALL go to DONE with misalign=1 and SHALL never raise valid_o.
REQ-025 An aligned request SHALL register addr, direction, wstrb and data, then go to BUS with valid_o=1 from the next cycle.
REQ-026 wstrb_o SHALL be ((1<<2^size)-1) << addr[2:0]; data_write_o SHALL be wdata << (8*addr[2:0]); for loads, wstrb_o and data_write_o SHALL be 0.
REQ-027 addr_o, req_o, data_write_o and wstrb_o SHALL stay stable while valid_o=1.
REQ-028 Handshake: in a cycle where valid_o=1 and ready_i=1, the block SHALL capture data_read_i and resp_i, go to DONE, and drop valid_o next cycle.
REQ-029 Ready_i in the same cycle valid_o rises SHALL complete the transfer, giving accept-to-done latency 2 cycles.
REQ-030 A per-transfer counter SHALL count BUS cycles with ready_i=0.
REQ-031 When the counter reaches TIMEOUT_CYCLES, the block SHALL drop valid_o, go to DONE with err=1 and drive rdata=0.
REQ-032 resp_i != 0 at the handshake SHALL set err=1 and force rdata=0.
REQ-033 Load result: shift data_read_i right by 8*addr[2:0], keep 2^size bytes, then sign- or zero-extend per lsu_unsigned_i; for size 3, lsu_unsigned_i SHALL be ignored.
REQ-034 DONE SHALL last exactly one cycle (lsu_done_o=1), then return to IDLE.
REQ-035 Store completions SHALL drive lsu_rdata_o=0.
REQ-036 lsu_valid_i outside IDLE SHALL be ignored.

Reset
REQ-037 While rst_n=0, all of the following SHALL be forced asynchronously: state=IDLE, counter=0, valid_o=0, req_o=0, addr_o=0, data_write_o=0, wstrb_o=0, lsu_done_o=0, lsu_rdata_o=0, lsu_err_o=0, lsu_misalign_o=0.
REQ-038 Reset asserted mid-transfer SHALL drop valid_o immediately, abandon the transfer, and produce no lsu_done_o.

Structure
REQ-039 The shared package SHALL hold the size encodings, the FSM state enum, and the RESP_OK constant.
REQ-040 The strobe, write shift, read shift and extension logic SHALL live in a combinational sub-module lsu_align.

Verification
REQ-041 Store D, addr 0x0200_4000, wdata 0x1234 -> valid_o, req_o=1, wstrb_o=0xFF, data_write_o=0x1234; ready_i=1 -> lsu_done_o 2 cycles after accept, err=0.
REQ-042 Store B, addr 0x0200_BFF9, wdata 0xAB -> wstrb_o=0x02, data_write_o=0xAB00.
REQ-043 Load H signed, addr offset 6, data_read_i=0x8001_0000_0000_0000 -> lsu_rdata_o=0xFFFF_FFFF_FFFF_8001; same load unsigned -> 0x8001.
REQ-044 Load W, addr 0x...0002 -> lsu_misalign_o=1 and lsu_done_o the next cycle; valid_o never high.
REQ-045 TIMEOUT_CYCLES=4, ready_i=0 -> valid_o high for 4 cycles, then lsu_err_o=1, lsu_rdata_o=0; resp_i=2'b10 at handshake -> lsu_err_o=1, lsu_rdata_o=0.
REQ-046 rst_n pulsed low while valid_o=1 -> valid_o=0 within the same cycle, no lsu_done_o, lsu_ready_o=1 after release.

Source files
------------

// File: rtl/lsu_bus_master_pkg.sv
// Shared types and constants for the LSU bus master: access sizes, FSM states, response codes.
package lsu_bus_master_pkg;

    typedef enum logic [1:0] {
        SizeB = 2'd0,
        SizeH = 2'd1,
        SizeW = 2'd2,
        SizeD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OK = 2'b00;

    // True when the low address bits are a multiple of the access size.
    function automatic logic is_aligned(input logic [2:0] offset, input size_e size);
        logic ok;
        ok = 1'b1;
        unique case (size)
            SizeB: ok = 1'b1;
            SizeH: ok = (offset[0] == 1'b0);
            SizeW: ok = (offset[1:0] == 2'b00);
            SizeD: ok = (offset == 3'b000);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: write strobes, write-data shift, and load shift plus sign/zero extension.
module lsu_align
    import lsu_bus_master_pkg::*;
(
    input  logic [2:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata_raw,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_lane,
    output logic [63:0] rdata_ext
);

    logic [5:0]  bit_off;
    logic [7:0]  strb_base;
    logic [63:0] rshift;

    assign bit_off    = {offset, 3'b000};
    assign wdata_lane = wdata << bit_off;
    assign rshift     = rdata_raw >> bit_off;
    assign wstrb      = strb_base << offset;

    always_comb begin
        strb_base = 8'h01;
        rdata_ext = rshift;
        unique case (size)
            SizeB: begin
                strb_base = 8'h01;
                rdata_ext = is_unsigned ? {56'd0, rshift[7:0]} : {{56{rshift[7]}}, rshift[7:0]};
            end
            SizeH: begin
                strb_base = 8'h03;
                rdata_ext = is_unsigned ? {48'd0, rshift[15:0]}
                                        : {{48{rshift[15]}}, rshift[15:0]};
            end
            SizeW: begin
                strb_base = 8'h0F;
                rdata_ext = is_unsigned ? {32'd0, rshift[31:0]}
                                        : {{32{rshift[31]}}, rshift[31:0]};
            end
            SizeD: begin
                strb_base = 8'hFF;
                rdata_ext = rshift;
            end
            default: begin
                strb_base = 8'h01;
                rdata_ext = rshift;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU-to-bus bridge: accepts one pipeline memory request, runs a valid/ready bus transfer with
// timeout, and returns an extended load result with error and misalignment flags.
module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid_i,
    input  logic        lsu_we_i,
    input  logic [63:0] lsu_addr_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [63:0] lsu_wdata_i,
    output logic        lsu_ready_o,
    output logic        lsu_done_o,
    output logic [63:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        lsu_misalign_o,
    output logic        valid_o,
    output logic        req_o,
    output logic [63:0] addr_o,
    output logic [63:0] data_write_o,
    output logic [7:0]  wstrb_o,
    input  logic        ready_i,
    input  logic [63:0] data_read_i,
    input  logic [1:0]  resp_i
);

    localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [63:0] addr_q, wdata_q, rdata_q;
    logic [7:0]  wstrb_q;
    logic        we_q, uns_q, err_q, mis_q;
    size_e       size_q;

    logic        load_req, set_result, res_err, res_mis;
    logic [63:0] res_rdata;
    logic        in_idle;
    logic [2:0]  align_off;
    size_e       align_size;
    logic [7:0]  lane_strb;
    logic [63:0] lane_wdata, load_ext;

    assign in_idle = (state_q == StIdle);

    // Write lanes come from the incoming request; read extension uses the registered transfer.
    assign align_off  = in_idle ? lsu_addr_i[2:0] : addr_q[2:0];
    assign align_size = in_idle ? size_e'(lsu_size_i) : size_q;

    lsu_align u_align (
        .offset      (align_off),
        .size        (align_size),
        .is_unsigned (uns_q),
        .wdata       (lsu_wdata_i),
        .rdata_raw   (data_read_i),
        .wstrb       (lane_strb),
        .wdata_lane  (lane_wdata),
        .rdata_ext   (load_ext)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_req   = 1'b0;
        set_result = 1'b0;
        res_err    = 1'b0;
        res_mis    = 1'b0;
        res_rdata  = 64'd0;
        unique case (state_q)
            StIdle: begin
                if (lsu_valid_i) begin
                    if (!is_aligned(lsu_addr_i[2:0], size_e'(lsu_size_i))) begin
                        state_d    = StDone;
                        set_result = 1'b1;
                        res_mis    = 1'b1;
                    end else begin
                        state_d  = StBus;
                        load_req = 1'b1;
                        cnt_d    = 16'd0;
                    end
                end
            end
            StBus: begin
                if (ready_i) begin
                    state_d    = StDone;
                    set_result = 1'b1;
                    res_err    = (resp_i != RESP_OK);
                    res_rdata  = (we_q || res_err) ? 64'd0 : load_ext;
                end else if (cnt_q + 16'd1 == TimeoutLimit) begin
                    state_d    = StDone;
                    set_result = 1'b1;
                    res_err    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            addr_q  <= 64'd0;
            we_q    <= 1'b0;
            size_q  <= SizeB;
            uns_q   <= 1'b0;
            wdata_q <= 64'd0;
            wstrb_q <= 8'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_req) begin
                addr_q  <= lsu_addr_i;
                we_q    <= lsu_we_i;
                size_q  <= size_e'(lsu_size_i);
                uns_q   <= lsu_unsigned_i;
                wdata_q <= lsu_we_i ? lane_wdata : 64'd0;
                wstrb_q <= lsu_we_i ? lane_strb : 8'd0;
            end
            if (set_result) begin
                rdata_q <= res_rdata;
                err_q   <= res_err;
                mis_q   <= res_mis;
            end
        end
    end

    assign lsu_ready_o    = in_idle;
    assign lsu_done_o     = (state_q == StDone);
    assign lsu_rdata_o    = rdata_q;
    assign lsu_err_o      = err_q;
    assign lsu_misalign_o = mis_q;
    assign valid_o        = (state_q == StBus);
    assign req_o          = we_q;
    assign addr_o         = addr_q;
    assign data_write_o   = wdata_q;
    assign wstrb_o        = wstrb_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed vector table, reset corner cases and
// randomized transfers checked against a byte-arithmetic reference model.
module tb_lsu_bus_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [63:0] lsu_addr_i = 64'd0;
    logic [1:0]  lsu_size_i = 2'd0;
    logic        lsu_unsigned_i = 1'b0;
    logic [63:0] lsu_wdata_i = 64'd0;
    logic        lsu_ready_o, lsu_done_o, lsu_err_o, lsu_misalign_o;
    logic [63:0] lsu_rdata_o;
    logic        valid_o, req_o;
    logic [63:0] addr_o, data_write_o;
    logic [7:0]  wstrb_o;
    logic        ready_i = 1'b0;
    logic [63:0] data_read_i = 64'd0;
    logic [1:0]  resp_i = 2'b00;

    int checks = 0;
    int failures = 0;

    lsu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_done_o     (lsu_done_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_err_o      (lsu_err_o),
        .lsu_misalign_o (lsu_misalign_o),
        .valid_o        (valid_o),
        .req_o          (req_o),
        .addr_o         (addr_o),
        .data_write_o   (data_write_o),
        .wstrb_o        (wstrb_o),
        .ready_i        (ready_i),
        .data_read_i    (data_read_i),
        .resp_i         (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        logic [63:0] rd;
        logic [1:0]  resp;
        int          delay;
        logic        exp_mis;
        logic        exp_err;
        logic [63:0] exp_rdata;
        logic [7:0]  exp_strb;
        logic [63:0] exp_lane;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: number of bytes is 2^size, the offset is addr mod 8, lanes are byte positions.
    function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [63:0] addr,
                                               input logic [1:0] size, input logic uns);
        int nb;
        int off;
        logic [63:0] v;
        logic [63:0] mask;
        nb   = 1 << size;
        off  = int'(addr % 64'd8);
        v    = rd >> (8 * off);
        if (nb == 8) return v;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (!uns && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic vec_t model(input vec_t r);
        vec_t e;
        int nb;
        int off;
        logic hs_err;
        e   = r;
        nb  = 1 << r.size;
        off = int'(r.addr % 64'd8);
        e.exp_mis   = (r.addr % 64'(nb)) != 64'd0;
        e.exp_strb  = r.we ? 8'(((1 << nb) - 1) << off) : 8'h00;
        e.exp_lane  = r.we ? (r.wdata << (8 * off)) : 64'd0;
        hs_err      = (r.delay >= TO) || (r.resp != 2'b00);
        e.exp_err   = !e.exp_mis && hs_err;
        e.exp_rdata = (e.exp_mis || r.we || hs_err) ? 64'd0 : model_load(r.rd, r.addr, r.size,
                                                                         r.uns);
        return e;
    endfunction

    task automatic run_txn(input int idx, input vec_t v);
        int nvalid;
        int exp_nvalid;
        @(negedge clk);
        check($sformatf("t%0d_ready_idle", idx), 64'(lsu_ready_o), 64'd1);
        lsu_valid_i    = 1'b1;
        lsu_we_i       = v.we;
        lsu_addr_i     = v.addr;
        lsu_size_i     = v.size;
        lsu_unsigned_i = v.uns;
        lsu_wdata_i    = v.wdata;
        @(negedge clk);
        lsu_valid_i = 1'b0;
        nvalid = 0;
        for (int k = 0; k < TO + 3; k++) begin
            if (!valid_o) break;
            nvalid++;
            check($sformatf("t%0d_addr_o", idx), addr_o, v.addr);
            check($sformatf("t%0d_req_o", idx), 64'(req_o), 64'(v.we));
            check($sformatf("t%0d_wstrb_o", idx), 64'(wstrb_o), 64'(v.exp_strb));
            check($sformatf("t%0d_data_write_o", idx), data_write_o, v.exp_lane);
            check($sformatf("t%0d_ready_busy", idx), 64'(lsu_ready_o), 64'd0);
            ready_i     = (k == v.delay);
            data_read_i = (k == v.delay) ? v.rd : {$urandom, $urandom};
            resp_i      = (k == v.delay) ? v.resp : 2'(($urandom_range(0, 3)));
            // Requests while busy must be ignored.
            lsu_valid_i = 1'($urandom_range(0, 1));
            lsu_addr_i  = {$urandom, $urandom};
            @(negedge clk);
        end
        ready_i     = 1'b0;
        lsu_valid_i = 1'b0;
        exp_nvalid  = v.exp_mis ? 0 : ((v.delay >= TO) ? TO : v.delay + 1);
        check($sformatf("t%0d_valid_cycles", idx), 64'(nvalid), 64'(exp_nvalid));
        check($sformatf("t%0d_done", idx), 64'(lsu_done_o), 64'd1);
        check($sformatf("t%0d_misalign", idx), 64'(lsu_misalign_o), 64'(v.exp_mis));
        check($sformatf("t%0d_err", idx), 64'(lsu_err_o), 64'(v.exp_err));
        check($sformatf("t%0d_rdata", idx), lsu_rdata_o, v.exp_rdata);
        @(negedge clk);
        check($sformatf("t%0d_done_one_cycle", idx), 64'(lsu_done_o), 64'd0);
        check($sformatf("t%0d_ready_after", idx), 64'(lsu_ready_o), 64'd1);
    endtask

    vec_t tbl[12];
    vec_t rv;
    int   done_seen;

    initial begin
        //        we    addr                    sz    uns   wdata                   rd                      resp  dly mis   err   rdata                   strb   lane
        tbl[0]  = '{1'b1, 64'h0000_0000_0200_4000, 2'd3, 1'b0, 64'h1234, 64'd0, 2'b00, 0, 1'b0, 1'b0,
                    64'd0, 8'hFF, 64'h1234};
        tbl[1]  = '{1'b1, 64'h0000_0000_0200_BFF9, 2'd0, 1'b0, 64'hAB, 64'd0, 2'b00, 1, 1'b0, 1'b0,
                    64'd0, 8'h02, 64'hAB00};
        tbl[2]  = '{1'b0, 64'h0000_0000_0000_1006, 2'd1, 1'b0, 64'd0, 64'h8001_0000_0000_0000, 2'b00,
                    0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'd0};
        tbl[3]  = '{1'b0, 64'h0000_0000_0000_1006, 2'd1, 1'b1, 64'd0, 64'h8001_0000_0000_0000, 2'b00,
                    2, 1'b0, 1'b0, 64'h8001, 8'h00, 64'd0};
        tbl[4]  = '{1'b0, 64'h0000_0000_0000_0002, 2'd2, 1'b0, 64'd0, 64'd0, 2'b00, 0, 1'b1, 1'b0,
                    64'd0, 8'h00, 64'd0};
        tbl[5]  = '{1'b0, 64'h0000_0000_0000_0010, 2'd3, 1'b0, 64'd0, 64'hFFFF, 2'b00, 99, 1'b0, 1'b1,
                    64'd0, 8'h00, 64'd0};
        tbl[6]  = '{1'b0, 64'h0000_0000_0000_0004, 2'd2, 1'b0, 64'd0, 64'hDEAD_BEEF_0000_0000, 2'b10,
                    0, 1'b0, 1'b1, 64'd0, 8'h00, 64'd0};
        tbl[7]  = '{1'b0, 64'h0000_0000_0000_0003, 2'd0, 1'b0, 64'd0, 64'h0000_0000_8000_0000, 2'b00,
                    1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'd0};
        tbl[8]  = '{1'b0, 64'h0000_0000_0000_0004, 2'd2, 1'b1, 64'd0, 64'h89AB_CDEF_0000_0000, 2'b00,
                    3, 1'b0, 1'b0, 64'h0000_0000_89AB_CDEF, 8'h00, 64'd0};
        tbl[9]  = '{1'b1, 64'h0000_0000_0000_0006, 2'd1, 1'b0, 64'hBEEF, 64'd0, 2'b00, 0, 1'b0, 1'b0,
                    64'd0, 8'hC0, 64'hBEEF_0000_0000_0000};
        tbl[10] = '{1'b1, 64'h0000_0000_0000_0004, 2'd3, 1'b0, 64'h55, 64'd0, 2'b00, 0, 1'b1, 1'b0,
                    64'd0, 8'h00, 64'd0};
        tbl[11] = '{1'b0, 64'h0000_0000_0000_0008, 2'd3, 1'b1, 64'd0, 64'h0123_4567_89AB_CDEF, 2'b01,
                    99, 1'b0, 1'b1, 64'd0, 8'h00, 64'd0};

        // Outputs while reset is held.
        #2;
        check("rst_ready", 64'(lsu_ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_req", 64'(req_o), 64'd0);
        check("rst_addr", addr_o, 64'd0);
        check("rst_wdata", data_write_o, 64'd0);
        check("rst_wstrb", 64'(wstrb_o), 64'd0);
        check("rst_done", 64'(lsu_done_o), 64'd0);
        check("rst_rdata", lsu_rdata_o, 64'd0);
        check("rst_err", 64'(lsu_err_o), 64'd0);
        check("rst_mis", 64'(lsu_misalign_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_txn(i, tbl[i]);

        // Reset in the middle of a transfer abandons it.
        @(negedge clk);
        lsu_valid_i = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_addr_i  = 64'h100;
        lsu_size_i  = 2'd3;
        @(negedge clk);
        lsu_valid_i = 1'b0;
        check("mid_valid_up", 64'(valid_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_valid_drop", 64'(valid_o), 64'd0);
        check("mid_done_low", 64'(lsu_done_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_ready_after", 64'(lsu_ready_o), 64'd1);
        done_seen = 0;
        repeat (TO + 2) begin
            @(negedge clk);
            if (lsu_done_o || valid_o) done_seen++;
        end
        check("mid_no_done", 64'(done_seen), 64'd0);

        // Randomized transfers against the reference model.
        for (int i = 0; i < 40; i++) begin
            rv.we    = 1'($urandom_range(0, 1));
            rv.size  = 2'($urandom_range(0, 3));
            rv.addr  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) rv.addr = rv.addr & ~((64'd1 << rv.size) - 64'd1);
            rv.uns   = 1'($urandom_range(0, 1));
            rv.wdata = {$urandom, $urandom} & ((rv.size == 2'd3) ? ~64'd0
                                                : ((64'd1 << (8 << rv.size)) - 64'd1));
            rv.rd    = {$urandom, $urandom};
            rv.resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rv.delay = $urandom_range(0, TO + 1);
            rv = model(rv);
            run_txn(100 + i, rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
